apb_xfer_arbiter: RTL

APB_XFER_ARBITER -- requirements
Module: apb_xfer_arbiter

---
 rtl/apb_xfer_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/apb_xfer_arbiter.sv
// Three-requester round-robin arbiter driving a single APB master port.
// All outputs are registered; an ACCESS-phase wait limit forces an error completion.
module apb_xfer_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int NREQ    = 3
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ-1:0]      REQ_WRITE,
    input  logic [32*NREQ-1:0]   REQ_ADDR,
    input  logic [32*NREQ-1:0]   REQ_WDATA,
    output logic [NREQ-1:0]      ACK,
    output logic [31:0]          RDATA,
    output logic                 ERR,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PADDR,
    output logic [31:0]          PWDATA,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Timeout fires on the edge that ends the TIMEOUT-th ACCESS cycle.
    localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t            r_state;
    logic [1:0]        r_last;
    logic [1:0]        r_gnt;
    logic [CW-1:0]     r_wait;
    logic [NREQ-1:0]   r_ack;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [31:0]       r_paddr;
    logic [31:0]       r_pwdata;

    logic [31:0]       w_addr  [NREQ];
    logic [31:0]       w_wdata [NREQ];
    logic [1:0]        w_c1;
    logic [1:0]        w_c2;
    logic [1:0]        w_pick;
    logic              w_any;
    logic [NREQ-1:0]   w_gnt_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign w_addr[gi]  = REQ_ADDR[32*gi +: 32];
            assign w_wdata[gi] = REQ_WDATA[32*gi +: 32];
        end
    endgenerate

    function automatic logic [1:0] f_next(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Search order: last+1, last+2, then last itself.
    assign w_c1         = f_next(r_last);
    assign w_c2         = f_next(w_c1);
    assign w_any        = |REQ;
    assign w_gnt_onehot = NREQ'(1) << r_gnt;

    always_comb begin
        w_pick = r_last;
        if (REQ[w_c1])
            w_pick = w_c1;
        else if (REQ[w_c2])
            w_pick = w_c2;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= S_IDLE;
            r_last    <= 2'd2;
            r_gnt     <= 2'd0;
            r_wait    <= '0;
            r_ack     <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt    <= w_pick;
                        r_last   <= w_pick;
                        r_pwrite <= REQ_WRITE[w_pick];
                        r_paddr  <= w_addr[w_pick];
                        r_pwdata <= w_wdata[w_pick];
                        r_wait   <= '0;
                        r_psel   <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        r_ack     <= w_gnt_onehot;
                        r_err     <= PSLVERR;
                        if (!r_pwrite)
                            r_rdata <= PRDATA;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if ((TIMEOUT != 0) && (r_wait == WAIT_LAST)) begin
                        r_ack     <= w_gnt_onehot;
                        r_err     <= 1'b1;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (r_wait != '1) begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ACK     = r_ack;
    assign ERR     = r_err;
    assign RDATA   = r_rdata;
    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;

endmodule
